gb_cpu_sched_queue: RTL and testbench

Parametrised m-cycle control sequencer for the GameBoy CPU core. It accepts a decoded instruction schedule of up to DEPTH control words in one load, then presents one word per m-cycle to the datapath (address/data bus, IDU, ALU, misc ops). It supports:

- a shorter alternate length when a condition check fails;
- stalls;
- flushes for interrupt dispatch;
- overlapped fetch, where the next instruction loads on the final cycle of the current one.

---
 rtl/gb_cpu_sched_queue.sv | 126 ++++++++++++
 tb/tb_gb_cpu_sched_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gb_cpu_sched_queue.sv
// rtl/gb_cpu_sched_queue.sv - m-cycle control-word sequencer with alt length, stall, flush and overlapped fetch
module gb_cpu_sched_queue #(
    parameter int                DEPTH    = 6,
    parameter int                CTRL_W   = 64,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
    parameter int                CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_i,
    input  logic [DEPTH*CTRL_W-1:0] load_ctrl_i,
    input  logic [CNT_W-1:0]        load_len_i,
    input  logic [CNT_W-1:0]        load_alt_len_i,
    input  logic                    cond_fail_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    output logic [CTRL_W-1:0]       ctrl_o,
    output logic                    busy_o,
    output logic                    last_o,
    output logic [CNT_W-1:0]        idx_o,
    output logic                    load_ack_o,
    output logic                    err_o
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W:0]   ONE_W   = (CNT_W + 1)'(1);

    state_t            state, state_nxt;
    logic [CTRL_W-1:0] slot [DEPTH];
    logic [CNT_W-1:0]  rem, idx, alt_len;
    logic              err_q;

    logic              adv, fail_end, last, accept, len_bad;
    logic [CNT_W:0]    idx_inc;
    logic [CNT_W-1:0]  len_cl, alt_cl;

    assign adv      = (state == RUN) && !stall_i;
    assign idx_inc  = {1'b0, idx} + ONE_W;
    assign fail_end = cond_fail_i && adv && ({1'b0, alt_len} <= idx_inc);
    assign last     = adv && ((rem == ONE_C) || fail_end);
    assign accept   = load_i && (flush_i || ((state == IDLE) && !stall_i) || last);

    // Illegal lengths are clamped into 1..DEPTH; alt length additionally capped by the main length.
    always_comb begin
        len_cl  = load_len_i;
        len_bad = 1'b0;
        if (load_len_i == '0) begin
            len_cl  = ONE_C;
            len_bad = 1'b1;
        end else if (load_len_i > DEPTH_C) begin
            len_cl  = DEPTH_C;
            len_bad = 1'b1;
        end
        alt_cl = load_alt_len_i;
        if (load_alt_len_i == '0) begin
            alt_cl  = ONE_C;
            len_bad = 1'b1;
        end else if (load_alt_len_i > DEPTH_C) begin
            alt_cl  = len_cl;
            len_bad = 1'b1;
        end else if (load_alt_len_i > len_cl) begin
            alt_cl = len_cl;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = RUN;
        else if (flush_i)
            state_nxt = IDLE;
        else if (last)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                slot[i] <= NOP_CTRL;
            rem     <= '0;
            idx     <= '0;
            alt_len <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && len_bad;
            if (accept) begin
                for (int i = 0; i < DEPTH; i++)
                    slot[i] <= load_ctrl_i[i*CTRL_W +: CTRL_W];
                rem     <= len_cl;
                alt_len <= alt_cl;
                idx     <= '0;
            end else if (flush_i) begin
                idx <= '0;
            end else if (adv) begin
                if (last) begin
                    idx <= '0;
                end else begin
                    // A failed condition shortens the schedule to alt_len total cycles.
                    rem <= cond_fail_i ? (alt_len - idx - ONE_C) : (rem - ONE_C);
                    for (int i = 0; i < DEPTH - 1; i++)
                        slot[i] <= slot[i+1];
                    slot[DEPTH-1] <= NOP_CTRL;
                    idx <= idx + ONE_C;
                end
            end
        end
    end

    assign ctrl_o     = (state == RUN) ? slot[0] : NOP_CTRL;
    assign busy_o     = (state == RUN);
    assign last_o     = last;
    assign idx_o      = idx;
    assign load_ack_o = accept;
    assign err_o      = err_q;

endmodule

// File: tb/tb_gb_cpu_sched_queue.sv
// tb/tb_gb_cpu_sched_queue.sv - randomized self-checking bench for gb_cpu_sched_queue
module tb_gb_cpu_sched_queue;

    localparam int DEPTH  = 6;
    localparam int CTRL_W = 64;
    localparam int CNT_W  = 3;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    load_i = 1'b0;
    logic [DEPTH*CTRL_W-1:0] load_ctrl_i = '0;
    logic [CNT_W-1:0]        load_len_i = '0;
    logic [CNT_W-1:0]        load_alt_len_i = '0;
    logic                    cond_fail_i = 1'b0;
    logic                    stall_i = 1'b0;
    logic                    flush_i = 1'b0;
    logic [CTRL_W-1:0]       ctrl_o;
    logic                    busy_o;
    logic                    last_o;
    logic [CNT_W-1:0]        idx_o;
    logic                    load_ack_o;
    logic                    err_o;

    gb_cpu_sched_queue #(.DEPTH(DEPTH), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .reset(reset), .load_i(load_i), .load_ctrl_i(load_ctrl_i),
        .load_len_i(load_len_i), .load_alt_len_i(load_alt_len_i),
        .cond_fail_i(cond_fail_i), .stall_i(stall_i), .flush_i(flush_i),
        .ctrl_o(ctrl_o), .busy_o(busy_o), .last_o(last_o), .idx_o(idx_o),
        .load_ack_o(load_ack_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Schedule-level model: the word list, its effective length and the current position.
    logic [DEPTH*CTRL_W-1:0] words;
    logic [CTRL_W-1:0]       m_words [DEPTH];
    bit                      m_busy = 0;
    int                      m_len = 0, m_alt = 0, m_idx = 0;
    bit                      m_err = 0;

    task automatic new_words();
        for (int i = 0; i < DEPTH; i++)
            words[i*CTRL_W +: CTRL_W] = {$urandom, $urandom};
    endtask

    function automatic int clamp_len(input int l);
        if (l < 1) return 1;
        if (l > DEPTH) return DEPTH;
        return l;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_idx = 0; m_err = 0; m_len = 0; m_alt = 0;
    endtask

    task automatic step(input bit ld, input int len, input int alt,
                        input bit cf, input bit st, input bit fl);
        bit exp_last, exp_ack;
        int cl;
        @(negedge clk);
        load_i = ld; load_len_i = CNT_W'(len); load_alt_len_i = CNT_W'(alt);
        cond_fail_i = cf; stall_i = st; flush_i = fl; load_ctrl_i = words;
        #1;
        exp_last = m_busy && !st && ((m_idx + 1 == m_len) || (cf && m_alt <= m_idx + 1));
        exp_ack  = ld && (fl || (!m_busy && !st) || exp_last);
        check_eq("ctrl", ctrl_o, m_busy ? m_words[m_idx] : '0);
        check_eq("busy", 64'(busy_o), 64'(m_busy));
        check_eq("last", 64'(last_o), 64'(exp_last));
        check_eq("idx", 64'(idx_o), 64'(m_idx));
        check_eq("ack", 64'(load_ack_o), 64'(exp_ack));
        check_eq("err", 64'(err_o), 64'(m_err));
        if (exp_ack) begin
            for (int i = 0; i < DEPTH; i++)
                m_words[i] = words[i*CTRL_W +: CTRL_W];
            cl     = clamp_len(len);
            m_len  = cl;
            m_alt  = (alt < 1) ? 1 : ((alt > cl) ? cl : alt);
            m_idx  = 0;
            m_busy = 1;
            m_err  = (len == 0) || (len > DEPTH);
        end else begin
            m_err = 0;
            if (fl) begin
                m_busy = 0; m_idx = 0;
            end else if (m_busy && !st) begin
                if (exp_last) begin
                    m_busy = 0; m_idx = 0;
                end else begin
                    if (cf) m_len = m_alt;
                    m_idx++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 1, 0, 0, 0);
    endtask

    initial begin
        int len, alt;
        new_words();
        @(negedge clk);
        #1;
        check_eq("rst_ctrl", ctrl_o, '0);
        check_eq("rst_busy", 64'(busy_o), 0);
        check_eq("rst_last", 64'(last_o), 0);
        check_eq("rst_idx", 64'(idx_o), 0);
        check_eq("rst_ack", 64'(load_ack_o), 0);
        check_eq("rst_err", 64'(err_o), 0);
        reset = 1'b0;
        model_reset();

        // Plain len-4 run
        new_words(); step(1, 4, 4, 0, 0, 0); idle(5);

        // Asynchronous reset mid-schedule at idx 2
        new_words(); step(1, 4, 4, 0, 0, 0); idle(2);
        @(negedge clk);
        load_i = 0; cond_fail_i = 0; stall_i = 0; flush_i = 0;
        check_eq("pre_rst_busy", 64'(busy_o), 1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_ctrl", ctrl_o, '0);
        check_eq("mid_rst_busy", 64'(busy_o), 0);
        check_eq("mid_rst_idx", 64'(idx_o), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        new_words(); step(1, 2, 2, 0, 0, 0); idle(3);

        // Condition failure: alt 2 then alt 1
        new_words(); step(1, 3, 2, 0, 0, 0); step(0, 1, 1, 1, 0, 0); idle(3);
        new_words(); step(1, 3, 1, 0, 0, 0); step(0, 1, 1, 1, 0, 0); idle(3);

        // Overlapped fetch with load held high
        new_words(); step(1, 3, 3, 0, 0, 0);
        new_words(); repeat (4) step(1, 2, 2, 0, 0, 0); idle(3);

        // Back-to-back len-1
        repeat (4) begin new_words(); step(1, 1, 1, 0, 0, 0); end
        idle(2);

        // Stall at idx 1, then flush+load during a stall
        new_words(); step(1, 3, 3, 0, 0, 0); step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0); step(0, 1, 1, 0, 1, 0); idle(3);
        new_words(); step(1, 3, 3, 0, 0, 0); step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 1, 0);
        new_words(); step(1, 2, 2, 0, 1, 1); idle(4);

        // Clamped lengths
        new_words(); step(1, 0, 1, 0, 0, 0); idle(3);
        new_words(); step(1, 7, 3, 0, 0, 0); idle(8);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            new_words();
            len = $urandom_range(7, 0);
            alt = $urandom_range(clamp_len(len), 1);
            step($urandom_range(99) < 35, len, alt,
                 $urandom_range(99) < 15, $urandom_range(99) < 15,
                 $urandom_range(99) < 5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
